// File: rtl/bp_pkg.sv
// Shared branch-predictor definitions: the BTB update record and the branch-type encoding.
package bp_pkg;

  localparam int unsigned BTB_PC_W = 30;

  localparam logic [1:0] BR_NONE = 2'b00;
  localparam logic [1:0] BR_COND = 2'b01;
  localparam logic [1:0] BR_JUMP = 2'b10;
  localparam logic [1:0] BR_IND  = 2'b11;

  typedef struct packed {
    logic [BTB_PC_W-1:0] pc;
    logic [1:0]          br_type;
    logic [BTB_PC_W-1:0] br_target;
  } btb_upd_t;

endpackage

// File: rtl/btb_upd_fifo.sv
// In-order queue of pending BTB writes with per-entry valid bits, a PC lookup port
// and in-place overwrite so repeated training of one PC occupies a single slot.
module btb_upd_fifo
  import bp_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clear,
  input  logic [BTB_PC_W-1:0] cmp_pc,
  output logic                cmp_hit,
  output logic [PTR_W-1:0]    cmp_idx,
  input  btb_upd_t            wr_data,
  input  logic                ovr_en,
  input  logic [PTR_W-1:0]    ovr_idx,
  input  logic                push,
  input  logic                pop,
  output btb_upd_t            head,
  output logic [PTR_W-1:0]    head_idx,
  output logic [CNT_W-1:0]    count
);

  btb_upd_t             mem_q [DEPTH];
  btb_upd_t             mem_d [DEPTH];
  logic [DEPTH-1:0]     valid_q, valid_d;
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;

  // The queue never holds duplicate PCs, so at most one entry can match.
  always_comb begin
    cmp_hit = 1'b0;
    cmp_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (mem_q[i].pc == cmp_pc)) begin
        cmp_hit = 1'b1;
        cmp_idx = PTR_W'(i);
      end
    end
  end

  always_comb begin
    // NOTE: every _d signal gets its hold value first, so no path leaves one unassigned and no latch is inferred.
    mem_d    = mem_q;
    valid_d  = valid_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear) begin
      valid_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (ovr_en) mem_d[ovr_idx] = wr_data;
      if (pop) begin
        valid_d[rd_ptr_q] = 1'b0;
        rd_ptr_d          = rd_ptr_q + PTR_W'(1);
      end
      if (push) begin
        mem_d[wr_ptr_q]   = wr_data;
        valid_d[wr_ptr_q] = 1'b1;
        wr_ptr_d          = wr_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // NOTE: payload storage has no reset; the valid bits alone say which entries mean anything.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      valid_q  <= valid_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head     = mem_q[rd_ptr_q];
  assign head_idx = rd_ptr_q;
  assign count    = count_q;

endmodule

// File: rtl/btb_update_ctrl.sv
// BTB training write sequencer: arbitrates EX and predecode requests into a
// coalescing queue and drains one registered write per cycle to the BTB port.
module btb_update_ctrl
  import bp_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  parameter  int unsigned PC_W  = BTB_PC_W,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ex_valid,
  output logic             ex_ready,
  input  logic [PC_W-1:0]  ex_pc,
  input  logic [PC_W-1:0]  ex_br_target,
  input  logic [1:0]       ex_br_type,
  input  logic             pd_valid,
  output logic             pd_ready,
  input  logic [PC_W-1:0]  pd_pc,
  input  logic [PC_W-1:0]  pd_br_target,
  input  logic [1:0]       pd_br_type,
  input  logic             flush,
  input  logic             upd_hold,
  output logic             update,
  output logic [PC_W-1:0]  update_pc,
  output logic [PC_W-1:0]  update_br_target,
  output logic [1:0]       update_br_type,
  output logic [CNT_W-1:0] q_count
);

  btb_upd_t         req;
  btb_upd_t         head;
  btb_upd_t         upd_rec_q, upd_rec_d;
  logic             update_q, update_d;
  logic             hit, accept, pop, coalesce, push;
  logic [PTR_W-1:0] hit_idx, head_idx;
  logic [CNT_W-1:0] count;

  // Readies look only at occupancy and flush, so a pop this cycle never opens a slot early.
  assign ex_ready = !flush && (count < CNT_W'(DEPTH));
  assign pd_ready = ex_ready && !ex_valid;

  always_comb begin
    req = '0;
    if (ex_valid) begin
      req.pc        = ex_pc;
      req.br_type   = ex_br_type;
      req.br_target = ex_br_target;
    end else begin
      req.pc        = pd_pc;
      req.br_type   = pd_br_type;
      req.br_target = pd_br_target;
    end
  end

  assign accept   = (ex_valid && ex_ready) || (pd_valid && pd_ready);
  assign pop      = (count != '0) && !upd_hold && !flush;
  // A hit on the head that leaves this cycle becomes a fresh enqueue instead.
  assign coalesce = accept && hit && !(pop && (hit_idx == head_idx));
  assign push     = accept && !coalesce;

  btb_upd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .clear   (flush),
    .cmp_pc  (req.pc),
    .cmp_hit (hit),
    .cmp_idx (hit_idx),
    .wr_data (req),
    .ovr_en  (coalesce),
    .ovr_idx (hit_idx),
    .push    (push),
    .pop     (pop),
    .head    (head),
    .head_idx(head_idx),
    .count   (count)
  );

  always_comb begin
    update_d  = pop;
    upd_rec_d = pop ? head : upd_rec_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      update_q  <= 1'b0;
      upd_rec_q <= '0;
    end else begin
      update_q  <= update_d;
      upd_rec_q <= upd_rec_d;
    end
  end

  assign update           = update_q;
  assign update_pc        = upd_rec_q.pc;
  assign update_br_type   = upd_rec_q.br_type;
  assign update_br_target = upd_rec_q.br_target;
  assign q_count          = count;

endmodule

// File: tb/tb_btb_update_ctrl.sv
// Self-checking bench for btb_update_ctrl: directed vector table, multi-cycle
// corner sequences, and random traffic against a queue-based reference model.
module tb_btb_update_ctrl;
  import bp_pkg::*;

  localparam int DEPTH = 4;
  localparam int PC_W  = 30;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             clk, rst;
  logic             ex_valid, ex_ready, pd_valid, pd_ready;
  logic [PC_W-1:0]  ex_pc, ex_br_target, pd_pc, pd_br_target;
  logic [1:0]       ex_br_type, pd_br_type;
  logic             flush, upd_hold, update;
  logic [PC_W-1:0]  update_pc, update_br_target;
  logic [1:0]       update_br_type;
  logic [CNT_W-1:0] q_count;

  int n_vec  = 0;
  int n_fail = 0;

  btb_update_ctrl #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
    .clk             (clk),
    .rst             (rst),
    .ex_valid        (ex_valid),
    .ex_ready        (ex_ready),
    .ex_pc           (ex_pc),
    .ex_br_target    (ex_br_target),
    .ex_br_type      (ex_br_type),
    .pd_valid        (pd_valid),
    .pd_ready        (pd_ready),
    .pd_pc           (pd_pc),
    .pd_br_target    (pd_br_target),
    .pd_br_type      (pd_br_type),
    .flush           (flush),
    .upd_hold        (upd_hold),
    .update          (update),
    .update_pc       (update_pc),
    .update_br_target(update_br_target),
    .update_br_type  (update_br_type),
    .q_count         (q_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic            ev;
    logic [PC_W-1:0] epc;
    logic [1:0]      etyp;
    logic [PC_W-1:0] etgt;
    logic            pv;
    logic [PC_W-1:0] ppc;
    logic [1:0]      ptyp;
    logic [PC_W-1:0] ptgt;
    logic            hold;
    logic            x_er, x_pr, x_upd;
    logic [PC_W-1:0] x_pc;
    logic [1:0]      x_typ;
    logic [PC_W-1:0] x_tgt;
    logic [CNT_W-1:0] x_cnt;
  } vec_t;

  vec_t vt[11];

  function automatic vec_t mk(
    input logic ev, input logic [PC_W-1:0] epc, input logic [1:0] etyp, input logic [PC_W-1:0] etgt,
    input logic pv, input logic [PC_W-1:0] ppc, input logic [1:0] ptyp, input logic [PC_W-1:0] ptgt,
    input logic hold, input logic er, input logic pr, input logic upd,
    input logic [PC_W-1:0] xpc, input logic [1:0] xtyp, input logic [PC_W-1:0] xtgt,
    input logic [CNT_W-1:0] cnt);
    vec_t v;
    v.ev = ev; v.epc = epc; v.etyp = etyp; v.etgt = etgt;
    v.pv = pv; v.ppc = ppc; v.ptyp = ptyp; v.ptgt = ptgt;
    v.hold = hold; v.x_er = er; v.x_pr = pr; v.x_upd = upd;
    v.x_pc = xpc; v.x_typ = xtyp; v.x_tgt = xtgt; v.x_cnt = cnt;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ex_valid = 1'b0; ex_pc = '0; ex_br_type = '0; ex_br_target = '0;
    pd_valid = 1'b0; pd_pc = '0; pd_br_type = '0; pd_br_target = '0;
    flush = 1'b0; upd_hold = 1'b0;
  endtask

  task automatic drive_ex(input logic [PC_W-1:0] pc, input logic [1:0] typ, input logic [PC_W-1:0] tgt);
    ex_valid = 1'b1; ex_pc = pc; ex_br_type = typ; ex_br_target = tgt;
  endtask

  task automatic check_out(input string tag, input logic upd, input logic [PC_W-1:0] pc,
                           input logic [1:0] typ, input logic [PC_W-1:0] tgt, input logic [CNT_W-1:0] cnt);
    check({tag, " update"}, 32'(update), 32'(upd));
    check({tag, " update_pc"}, 32'(update_pc), 32'(pc));
    check({tag, " update_br_type"}, 32'(update_br_type), 32'(typ));
    check({tag, " update_br_target"}, 32'(update_br_target), 32'(tgt));
    check({tag, " q_count"}, 32'(q_count), 32'(cnt));
  endtask

  task automatic run_table();
    vt[0]  = mk(1, 'h100, BR_COND, 'h200, 0, 0, 0, 0,             0, 1, 0, 0, 0, 0, 0, 1);
    vt[1]  = mk(0, 0, 0, 0,                0, 0, 0, 0,             0, 1, 1, 1, 'h100, BR_COND, 'h200, 0);
    vt[2]  = mk(0, 0, 0, 0,                0, 0, 0, 0,             0, 1, 1, 0, 'h100, BR_COND, 'h200, 0);
    vt[3]  = mk(1, 'h300, BR_JUMP, 'h310, 1, 'h400, BR_IND, 'h410, 0, 1, 0, 0, 'h100, BR_COND, 'h200, 1);
    vt[4]  = mk(0, 0, 0, 0,                1, 'h400, BR_IND, 'h410, 0, 1, 1, 1, 'h300, BR_JUMP, 'h310, 1);
    vt[5]  = mk(0, 0, 0, 0,                0, 0, 0, 0,             0, 1, 1, 1, 'h400, BR_IND, 'h410, 0);
    vt[6]  = mk(0, 0, 0, 0,                0, 0, 0, 0,             0, 1, 1, 0, 'h400, BR_IND, 'h410, 0);
    vt[7]  = mk(1, 'h10, BR_COND, 'h33,    0, 0, 0, 0,             1, 1, 0, 0, 'h400, BR_IND, 'h410, 1);
    vt[8]  = mk(1, 'h10, BR_COND, 'h44,    0, 0, 0, 0,             1, 1, 0, 0, 'h400, BR_IND, 'h410, 1);
    vt[9]  = mk(0, 0, 0, 0,                0, 0, 0, 0,             0, 1, 1, 1, 'h10, BR_COND, 'h44, 0);
    vt[10] = mk(0, 0, 0, 0,                0, 0, 0, 0,             0, 1, 1, 0, 'h10, BR_COND, 'h44, 0);
    for (int i = 0; i < 11; i++) begin
      ex_valid = vt[i].ev; ex_pc = vt[i].epc; ex_br_type = vt[i].etyp; ex_br_target = vt[i].etgt;
      pd_valid = vt[i].pv; pd_pc = vt[i].ppc; pd_br_type = vt[i].ptyp; pd_br_target = vt[i].ptgt;
      upd_hold = vt[i].hold; flush = 1'b0;
      #1;
      check($sformatf("v%0d ex_ready", i), 32'(ex_ready), 32'(vt[i].x_er));
      check($sformatf("v%0d pd_ready", i), 32'(pd_ready), 32'(vt[i].x_pr));
      step();
      check_out($sformatf("v%0d", i), vt[i].x_upd, vt[i].x_pc, vt[i].x_typ, vt[i].x_tgt, vt[i].x_cnt);
    end
    idle();
  endtask

  task automatic run_full_hold();
    logic [PC_W-1:0] got[$];
    logic accepted;
    int cyc;
    idle();
    upd_hold = 1'b1;
    for (int k = 0; k < DEPTH; k++) begin
      drive_ex(PC_W'('h20 + k), BR_JUMP, PC_W'('h900 + k));
      step();
    end
    drive_ex('h24, BR_JUMP, 'h924);
    #1;
    check("full q_count", 32'(q_count), 32'(DEPTH));
    check("full ex_ready", 32'(ex_ready), 0);
    check("full pd_ready", 32'(pd_ready), 0);
    for (int k = 0; k < 2; k++) begin
      step();
      check($sformatf("stall%0d q_count", k), 32'(q_count), 32'(DEPTH));
      check($sformatf("stall%0d update", k), 32'(update), 0);
    end
    upd_hold = 1'b0;
    #1;
    check("full pop ex_ready", 32'(ex_ready), 0);
    cyc = 0;
    while (got.size() < 5 && cyc < 20) begin
      accepted = ex_valid && ex_ready;
      step();
      if (accepted) ex_valid = 1'b0;
      if (update) got.push_back(update_pc);
      cyc++;
    end
    check("drain count", 32'(got.size()), 5);
    for (int k = 0; k < got.size(); k++)
      check($sformatf("drain order %0d", k), 32'(got[k]), 32'('h20 + k));
    step();
    check("drain empty q_count", 32'(q_count), 0);
    check("drain empty update", 32'(update), 0);
    idle();
  endtask

  task automatic run_flush();
    int pulses;
    idle();
    upd_hold = 1'b1;
    for (int k = 0; k < 3; k++) begin
      drive_ex(PC_W'('h50 + k), BR_COND, PC_W'('h600 + k));
      step();
    end
    ex_valid = 1'b0;
    #1;
    check("preflush q_count", 32'(q_count), 3);
    upd_hold = 1'b0;
    flush = 1'b1;
    drive_ex('h60, BR_IND, 'h660);
    #1;
    check("flush ex_ready", 32'(ex_ready), 0);
    check("flush pd_ready", 32'(pd_ready), 0);
    step();
    idle();
    check("postflush q_count", 32'(q_count), 0);
    check("postflush update", 32'(update), 0);
    pulses = 0;
    for (int k = 0; k < 5; k++) begin
      step();
      if (update) pulses++;
    end
    check("postflush pulses", 32'(pulses), 0);
    check("postflush idle q_count", 32'(q_count), 0);
  endtask

  task automatic run_async_reset();
    idle();
    upd_hold = 1'b1;
    for (int k = 0; k < 3; k++) begin
      drive_ex(PC_W'('h70 + k), BR_JUMP, PC_W'('h700 + k));
      step();
    end
    idle();
    step();
    check("middrain update", 32'(update), 1);
    #2;
    rst = 1'b1;
    #1;
    check_out("async rst", 1'b0, '0, '0, '0, '0);
    @(negedge clk);
    rst = 1'b0;
    drive_ex('h100, BR_COND, 'h200);
    step();
    idle();
    check_out("rerun e1", 1'b0, '0, '0, '0, 1);
    step();
    check_out("rerun e2", 1'b1, 'h100, BR_COND, 'h200, 0);
    step();
    check_out("rerun e3", 1'b0, 'h100, BR_COND, 'h200, 0);
  endtask

  task automatic run_random(input int cycles);
    btb_upd_t mq[$];
    btb_upd_t m_rec, req;
    logic m_upd, exp_er, exp_pr, popped, hit;
    idle();
    @(negedge clk);
    rst = 1'b1;
    #2;
    rst = 1'b0;
    m_rec = '0;
    m_upd = 1'b0;
    for (int c = 0; c < cycles; c++) begin
      ex_valid     = ($urandom_range(0, 99) < 50);
      ex_pc        = PC_W'($urandom_range(0, 7));
      ex_br_type   = 2'($urandom_range(0, 3));
      ex_br_target = PC_W'($urandom);
      pd_valid     = ($urandom_range(0, 99) < 50);
      pd_pc        = PC_W'($urandom_range(0, 7));
      pd_br_type   = 2'($urandom_range(0, 3));
      pd_br_target = PC_W'($urandom);
      upd_hold     = ($urandom_range(0, 99) < 30);
      flush        = ($urandom_range(0, 99) < 4);
      #1;
      exp_er = !flush && (mq.size() < DEPTH);
      exp_pr = exp_er && !ex_valid;
      check($sformatf("rnd%0d ex_ready", c), 32'(ex_ready), 32'(exp_er));
      check($sformatf("rnd%0d pd_ready", c), 32'(pd_ready), 32'(exp_pr));
      popped = (mq.size() > 0) && !upd_hold && !flush;
      if (flush) begin
        mq.delete();
      end else begin
        if (popped) m_rec = mq.pop_front();
        if ((ex_valid && exp_er) || (pd_valid && exp_pr)) begin
          if (ex_valid) req = '{pc: ex_pc, br_type: ex_br_type, br_target: ex_br_target};
          else          req = '{pc: pd_pc, br_type: pd_br_type, br_target: pd_br_target};
          hit = 1'b0;
          foreach (mq[j]) begin
            if (mq[j].pc == req.pc) begin
              mq[j] = req;
              hit = 1'b1;
            end
          end
          if (!hit) mq.push_back(req);
        end
      end
      m_upd = popped;
      step();
      check_out($sformatf("rnd%0d", c), m_upd, m_rec.pc, m_rec.br_type, m_rec.br_target,
                CNT_W'(mq.size()));
    end
    idle();
  endtask

  initial begin
    idle();
    rst = 1'b1;
    #12;
    check_out("reset", 1'b0, '0, '0, '0, '0);
    @(negedge clk);
    rst = 1'b0;
    run_table();
    run_full_hold();
    run_flush();
    run_async_reset();
    run_random(400);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
